// File: rtl/brq_pkg.sv
// Shared types and constants for the branch resolve queue.
// Optional statistics counters are enabled with the BRQ_STATS_EN macro.
package brq_pkg;

  localparam int          DEPTH_DEFAULT     = 4;
  localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

  typedef struct packed {
    logic        taken;
    logic [31:0] addr;
    logic [31:0] target;
  } brq_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } brq_state_e;

endpackage

// File: rtl/brq_fifo.sv
// Program-order storage for predicted branches: push, pop, clear and occupancy count.
// Clear has priority over a same-cycle push or pop.
module brq_fifo
  import brq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  input  brq_entry_t                   wdata_i,
  output brq_entry_t                   rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  brq_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PW'(1);
      if (pop_i)  rptr_q <= rptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the entry array is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (push_i && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks in-flight predicted branches, checks them against execute outcomes and pulses Flush on a mispredict.
// Define BRQ_STATS_EN to enable the Branch_count / Mispredict_count counters.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       Pred_valid,
  input  logic                       Pred_taken,
  input  logic [31:0]                Pred_addr,
  input  logic [31:0]                Pred_target,
  output logic                       Pred_ready,
  input  logic                       Res_valid,
  input  logic                       Res_taken,
  input  logic [31:0]                Res_target,
  output logic                       Flush,
  output logic [31:0]                Redirect_addr,
  output logic                       Empty,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic [31:0]                Branch_count,
  output logic [31:0]                Mispredict_count
);

  brq_state_e  state_q;
  logic        flush_q;
  logic [31:0] redirect_q, redirect_d;
  brq_entry_t  head, new_entry;
  logic        run, full, push, resolve, mispredict;

  assign run        = (state_q == ST_RUN);
  assign Pred_ready = run && !full;
  assign push       = Pred_valid && Pred_ready;
  assign resolve    = Res_valid && run && !Empty;
  assign mispredict = resolve &&
                      ((Res_taken != head.taken) || (Res_taken && (Res_target != head.target)));
  assign redirect_d = Res_taken ? Res_target : head.addr + DELAY_SLOT_OFFSET;
  assign new_entry  = '{taken: Pred_taken, addr: Pred_addr, target: Pred_target};

  // A mispredict empties the queue, dropping any push offered in the same cycle.
  brq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push_i  (push),
    .pop_i   (resolve),
    .clear_i (mispredict),
    .wdata_i (new_entry),
    .rdata_o (head),
    .count_o (Count),
    .full_o  (full),
    .empty_o (Empty)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_RUN;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mispredict) begin
            state_q    <= ST_FLUSH;
            flush_q    <= 1'b1;
            redirect_q <= redirect_d;
          end
        end
        ST_FLUSH: begin
          state_q <= ST_RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign Flush         = flush_q;
  assign Redirect_addr = redirect_q;

`ifdef BRQ_STATS_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (resolve)    branch_cnt_q     <= branch_cnt_q + 32'd1;
      if (mispredict) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign Branch_count     = branch_cnt_q;
  assign Mispredict_count = mispredict_cnt_q;
`else
  assign Branch_count     = '0;
  assign Mispredict_count = '0;
`endif

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of in-flight predicted branches held (power of two, 2..16).
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Pred_valid  input  1  fetch presents a predicted branch this cycle.
REQ-005 SHALL have port Pred_taken  input  1  predictor's Taken output for that branch.
REQ-006 SHALL have port Pred_addr  input  32  branch instruction address.
REQ-007 SHALL have port Pred_target  input  32  predicted target; meaningful only when Pred_taken=1.
REQ-008 SHALL have port Pred_ready  output  1  queue accepts a push this cycle.
REQ-009 SHALL have port Res_valid  input  1  execute resolves the oldest queued branch.
REQ-010 SHALL have port Res_taken  input  1  actual branch outcome.
REQ-011 SHALL have port Res_target  input  32  actual target; meaningful only when Res_taken=1.
REQ-012 SHALL have port Flush  output  1  one-cycle pipeline flush pulse.
REQ-013 SHALL have port Redirect_addr  output  32  correct fetch address, valid while Flush=1.
REQ-014 SHALL have port Empty  output  1  no entries queued.
REQ-015 SHALL have port Count  output  clog2(DEPTH+1)  number of entries queued.
REQ-016 SHALL have ports Branch_count and Mispredict_count  output  32 each  resolution statistics (see Configuration).

Function
REQ-017 SHALL store entries {taken, addr, target} in strict program order (FIFO).
REQ-018 SHALL drive Pred_ready=1 iff state=RUN and Count<DEPTH; push occurs iff Pred_valid && Pred_ready.
REQ-019 SHALL NOT accept a push when full even if a resolve frees the head in the same cycle.
REQ-020 SHALL pop the head when Res_valid=1, state=RUN, Empty=0; Res_valid while Empty=1 or in FLUSH SHALL be ignored.
REQ-021 SHALL classify a mispredict as Res_taken != head.taken, or both taken and Res_target != head.target.
REQ-022 SHALL compute Redirect_addr = Res_target if Res_taken, else head.addr + 8 (delay slot), 32-bit modulo.
REQ-023 SHALL implement FSM states RUN and FLUSH; RUN->FLUSH on mispredicting resolve; FLUSH->RUN unconditionally after one cycle.
REQ-024 SHALL assert Flush (registered) exactly one cycle after the mispredicting Res_valid cycle, for exactly one cycle.
REQ-025 SHALL clear all queued entries on entering FLUSH; a push in the mispredict cycle SHALL be discarded.
REQ-026 SHALL hold Pred_ready=0 and ignore Pred_valid/Res_valid during FLUSH.
REQ-027 SHALL hold Redirect_addr at its last value until the next flush.
REQ-028 SHALL, on simultaneous correct resolve and push (not full), leave Count unchanged.

Reset
REQ-029 SHALL on RESET: state=RUN, Count=0, Empty=1, Flush=0, Redirect_addr=0, counters=0, pointers=0; Pred_ready=1 the first cycle after.
REQ-030 SHALL let RESET override everything, including a pending flush and same-cycle push/resolve.

Configuration
REQ-031 SHALL with BRQ_STATS_EN defined increment Branch_count per accepted resolve and Mispredict_count per mispredict, wrapping at 2^32.
REQ-032 SHALL without BRQ_STATS_EN keep both ports present, tied to 0, with no counter flops.

Structure
REQ-033 SHALL place DEPTH default, entry struct, FSM state encoding and DELAY_SLOT_OFFSET=8 in shared package brq_pkg.
REQ-034 SHALL implement storage/pointers in one sub-module brq_fifo (push, pop, clear, count).

Verification
REQ-035 Push NT @0x00400010, resolve NT -> no Flush, Count 1->0, Branch_count=1.
REQ-036 Push NT @0x00400020, resolve T tgt 0x00400100 -> next cycle Flush=1, Redirect_addr=0x00400100, Empty=1, Mispredict_count=1.
REQ-037 Push T @0x00400030 tgt 0x00400200, resolve NT -> Flush=1, Redirect_addr=0x00400038.
REQ-038 Push 4 entries -> Pred_ready=0; 5th push with simultaneous resolve not accepted; Count=3, then Pred_ready=1.
REQ-039 Two queued, head mispredicts with simultaneous push -> push dropped, Count=0, Pred_ready=0 in FLUSH cycle, 1 after.
REQ-040 RESET with 3 entries and pending flush -> next cycle Count=0, Flush=0, counters=0, Pred_ready=1.
